// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh scheduler: interval timer, refresh debt, and the
// PRECHARGE-ALL / AUTO-REFRESH command sequencer granted by the arbiter.
module sdram_aref_ctrl #(
    parameter int REF_INTERVAL = 750,
    parameter int T_RP         = 2,
    parameter int T_RC         = 7,
    parameter int REF_CNT      = 2,
    parameter int MAX_DEBT     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_end,
    input  logic        ref_en,
    output logic        ref_req,
    output logic        flag_ref_end,
    output logic [3:0]  aref_cmd,
    output logic [12:0] aref_addr,
    output logic [1:0]  aref_ba,
    output logic        ref_overrun
);

    localparam int TW = $clog2(REF_INTERVAL);
    localparam int DW = $clog2(MAX_DEBT + 1);
    localparam int WW = $clog2((T_RC > T_RP ? T_RC : T_RP) + 1);
    localparam int CW = $clog2(REF_CNT + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TRP,
        S_AREF,
        S_TRC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_tim;
    logic [DW-1:0]   r_debt;
    logic            r_overrun;
    logic [WW-1:0]   r_wait;
    logic [WW-1:0]   w_wait_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_tick;
    logic            w_dec;

    assign w_tick = init_end && (r_tim == TW'(REF_INTERVAL - 1));
    assign w_dec  = (r_state == S_DONE);

    // Interval timer: held at zero until init is done, wrap is the tick
    always_ff @(posedge clk) begin
        if (rst || !init_end) begin
            r_tim <= '0;
        end else if (w_tick) begin
            r_tim <= '0;
        end else begin
            r_tim <= r_tim + TW'(1);
        end
    end

    // Refresh debt: +1 per tick (saturating), -1 per completed sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            r_debt    <= '0;
            r_overrun <= 1'b0;
        end else if (w_tick && !w_dec) begin
            if (r_debt == DW'(MAX_DEBT)) begin
                r_overrun <= 1'b1;
            end else begin
                r_debt <= r_debt + DW'(1);
            end
        end else if (w_dec && !w_tick) begin
            r_debt <= r_debt - DW'(1);
        end
    end

    // Sequencer state, spacing counter and AUTO-REFRESH counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and command decode from the registered state
    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait;
        w_cnt_nxt    = r_cnt;
        aref_cmd     = CMD_NOP;
        aref_addr    = '0;
        flag_ref_end = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (ref_en && (r_debt != '0)) begin
                    w_state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                aref_cmd      = CMD_PRE;
                aref_addr[10] = 1'b1;
                w_wait_nxt    = '0;
                w_state_nxt   = S_TRP;
            end
            S_TRP: begin
                if (r_wait == WW'(T_RP - 1)) begin
                    w_state_nxt = S_AREF;
                end else begin
                    w_wait_nxt = r_wait + WW'(1);
                end
            end
            S_AREF: begin
                aref_cmd    = CMD_AREF;
                w_cnt_nxt   = r_cnt + CW'(1);
                w_wait_nxt  = '0;
                w_state_nxt = S_TRC;
            end
            S_TRC: begin
                if (r_wait == WW'(T_RC - 1)) begin
                    if (r_cnt < CW'(REF_CNT)) begin
                        w_state_nxt = S_AREF;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_wait_nxt = r_wait + WW'(1);
                end
            end
            S_DONE: begin
                flag_ref_end = 1'b1;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign ref_req     = (r_state == S_IDLE) && (r_debt != '0);
    assign aref_ba     = 2'b00;
    assign ref_overrun = r_overrun;

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Bench for sdram_aref_ctrl: directed scenarios plus random arbiter traffic,
// scored every cycle against a timeline model of the refresh rules.
module tb_sdram_aref_ctrl;

    localparam int RI  = 750;
    localparam int TRP = 2;
    localparam int TRC = 7;
    localparam int RC  = 2;
    localparam int MD  = 4;
    localparam int LAT = 2 + TRP + RC * (1 + TRC);

    logic        clk = 1'b0;
    logic        rst;
    logic        init_end;
    logic        ref_en;
    logic        ref_req;
    logic        flag_ref_end;
    logic [3:0]  aref_cmd;
    logic [12:0] aref_addr;
    logic [1:0]  aref_ba;
    logic        ref_overrun;

    sdram_aref_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .init_end     (init_end),
        .ref_en       (ref_en),
        .ref_req      (ref_req),
        .flag_ref_end (flag_ref_end),
        .aref_cmd     (aref_cmd),
        .aref_addr    (aref_addr),
        .aref_ba      (aref_ba),
        .ref_overrun  (ref_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rq;
        logic        fl;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic        ov;
    } obs_t;

    obs_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Model: m_run = edges init_end has been high, m_off = offset into the
    // running sequence (-1 when idle), m_debt = outstanding refresh ticks.
    int   m_run  = 0;
    int   m_off  = -1;
    int   m_debt = 0;
    bit   m_ov   = 1'b0;
    bit   m_tick;
    bit   m_dec;
    int   m_dold;
    obs_t m_exp;

    function automatic bit is_aref(int o);
        int d;
        d = o - (1 + TRP);
        if (d < 0) return 1'b0;
        if ((d % (1 + TRC)) != 0) return 1'b0;
        return (d / (1 + TRC)) < RC;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_run  = 0;
            m_off  = -1;
            m_debt = 0;
            m_ov   = 1'b0;
        end else begin
            if (init_end) begin
                m_run++;
                m_tick = ((m_run % RI) == 0);
            end else begin
                m_run  = 0;
                m_tick = 1'b0;
            end
            m_dec  = (m_off == LAT - 1);
            m_dold = m_debt;
            if (m_tick && !m_dec) begin
                if (m_debt == MD) m_ov = 1'b1;
                else m_debt++;
            end else if (m_dec && !m_tick) begin
                m_debt--;
            end
            if (m_off == LAT - 1) m_off = -1;
            else if (m_off >= 0) m_off++;
            else if (ref_en && m_dold > 0) m_off = 0;
        end
        m_exp.rq   = (m_off < 0) && (m_debt != 0);
        m_exp.fl   = (m_off == LAT - 1);
        m_exp.cmd  = (m_off == 0) ? 4'b0010 :
                     (m_off > 0 && is_aref(m_off)) ? 4'b0001 : 4'b0111;
        m_exp.addr = (m_off == 0) ? 13'h0400 : 13'h0000;
        m_exp.ba   = 2'b00;
        m_exp.ov   = m_ov;
        sb_q.push_back(m_exp);
    end

    obs_t mon_e;
    obs_t mon_a;

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_a.rq   = ref_req;
            mon_a.fl   = flag_ref_end;
            mon_a.cmd  = aref_cmd;
            mon_a.addr = aref_addr;
            mon_a.ba   = aref_ba;
            mon_a.ov   = ref_overrun;
            n_checks++;
            if (mon_a !== mon_e) begin
                n_fail++;
                $display("FAIL outputs cyc %0d: got rq=%b fl=%b cmd=%b addr=%h ba=%b ov=%b, want rq=%b fl=%b cmd=%b addr=%h ba=%b ov=%b",
                         cyc, mon_a.rq, mon_a.fl, mon_a.cmd, mon_a.addr, mon_a.ba, mon_a.ov,
                         mon_e.rq, mon_e.fl, mon_e.cmd, mon_e.addr, mon_e.ba, mon_e.ov);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expired(string what);
        n_checks++;
        n_fail++;
        $display("FAIL timeout %s: got no event, want event within bound", what);
    endtask

    task automatic wait_debt(int bound);
        int k;
        k = 0;
        while (!(m_debt > 0 && m_off < 0) && k < bound) begin
            step();
            k++;
        end
        if (!(m_debt > 0 && m_off < 0)) expired("debt");
    endtask

    // Arbiter grant: raise ref_en, optionally drop it early, release on DONE
    task automatic grant(int drop_at);
        int k;
        ref_en = 1'b1;
        k = 0;
        while (m_off < 0 && k < 5) begin
            step();
            k++;
        end
        if (m_off < 0) begin
            expired("start");
            ref_en = 1'b0;
            return;
        end
        k = 0;
        while (m_off != LAT - 1 && k < 2 * LAT) begin
            if (k == drop_at) ref_en = 1'b0;
            step();
            k++;
        end
        if (m_off != LAT - 1) expired("done");
        ref_en = 1'b0;
        step();
    endtask

    int hold;

    initial begin
        rst      = 1'b1;
        init_end = 1'b0;
        ref_en   = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // grant with no debt is ignored
        ref_en = 1'b1;
        repeat (5) step();
        ref_en = 1'b0;

        // first tick RI edges after init_end
        init_end = 1'b1;
        repeat (RI + 2) step();
        grant(-1);
        repeat (3) step();
        ref_en = 1'b1;
        repeat (4) step();
        ref_en = 1'b0;

        // five intervals without grant: saturation then overrun
        repeat (5 * RI + 5) step();
        for (int i = 0; i < 4; i++) begin
            grant(-1);
            repeat (2) step();
        end
        repeat (3) step();

        // line up the sequence so DONE coincides with a tick
        hold = 0;
        while (!(m_debt == 1 && m_off < 0 && (m_run % RI) == RI - LAT - 1) && hold < 2 * RI) begin
            step();
            hold++;
        end
        if (hold >= 2 * RI) expired("tick align");
        grant(-1);
        repeat (2) step();
        grant(-1);

        // grant dropped early: sequence still completes
        wait_debt(2 * RI);
        grant(6);
        repeat (2) step();

        // reset during TRC aborts the sequence
        wait_debt(2 * RI);
        ref_en = 1'b1;
        hold = 0;
        while (m_off != 8 && hold < 40) begin
            step();
            hold++;
        end
        if (m_off != 8) expired("trc");
        rst    = 1'b1;
        ref_en = 1'b0;
        step();
        rst      = 1'b0;
        init_end = 1'b0;
        repeat (10) step();
        init_end = 1'b1;
        repeat (RI + 5) step();

        // random arbiter traffic, init_end glitches, rare resets
        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 2499) == 0);
            if (hold > 0) begin
                hold--;
                init_end = (hold == 0);
            end else if ($urandom_range(0, 799) == 0) begin
                hold = $urandom_range(1, 20);
                init_end = 1'b0;
            end
            if (m_off == LAT - 1) ref_en = 1'b0;
            else if (m_off >= 0) ref_en = ref_en && ($urandom_range(0, 15) != 0);
            else ref_en = ($urandom_range(0, 3) == 0);
            step();
        end
        rst      = 1'b0;
        init_end = 1'b1;
        ref_en   = 1'b0;
        repeat (2) step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
